// File: rtl/uart_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the UART TX arbiter.
package uart_arb_pkg;

   // Arbiter states: waiting for a requester, or streaming the owner's message.
   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   // End-of-line byte that requesters normally flag as the last byte of a message.
   localparam logic [7:0] ASCII_NL = 8'h0A;

   // Widest requester set the pick function handles.
   localparam int unsigned RR_MAX_REQ = 8;
   localparam int unsigned RR_IDX_W   = 3;

   // First set bit of req[n-1:0], searching upward from ptr with wrap; 0 when none is set.
   function automatic logic [RR_IDX_W-1:0] rr_pick(
      input logic [RR_MAX_REQ-1:0] req,
      input logic [RR_IDX_W-1:0]   ptr,
      input int unsigned           n
   );
      logic [RR_IDX_W-1:0] win;
      logic                found;
      int unsigned         idx;
      win   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= n) begin
            idx = idx - n;
         end
         if ((k < n) && !found && req[idx[RR_IDX_W-1:0]]) begin
            win   = idx[RR_IDX_W-1:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_pointer_picker.sv
// Combinational round-robin picker: masked priority encode of req starting at ptr.
module rr_pointer_picker #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [ID_W-1:0]  winner_o,
   output logic             any_o
);
   import uart_arb_pkg::*;

   logic [RR_MAX_REQ-1:0] req_ext;
   logic [RR_IDX_W-1:0]   ptr_ext;

   // Widen to the pick function's fixed width; unused high requests read as zero.
   assign req_ext  = RR_MAX_REQ'(req_i);
   assign ptr_ext  = RR_IDX_W'(ptr_i);

   // Winner index and a flag that any request is present.
   assign winner_o = ID_W'(rr_pick(req_ext, ptr_ext, N_REQ));
   assign any_o    = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART TX byte channel among N_REQ requesters.
// The owner keeps the channel until it hands over a last-flagged byte, hits the length cap,
// or stalls for too long.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned MAX_MSG      = 64,
   parameter int unsigned STALL_CYCLES = 1024,
   localparam int unsigned ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   input  logic                 output_busy,
   output logic                 output_en,
   output logic [7:0]           output_data,
   output logic                 grant_valid,
   output logic [ID_W-1:0]      grant_id,
   output logic                 err_stall,
   output logic                 err_len
);
   import uart_arb_pkg::*;

   localparam int unsigned BC_W = $clog2(MAX_MSG + 1);
   localparam int unsigned SC_W = $clog2(STALL_CYCLES + 1);

   arb_state_e        state_q;
   logic [ID_W-1:0]   rr_ptr_q;
   logic [ID_W-1:0]   rr_ptr_d;
   logic [ID_W-1:0]   grant_id_q;
   logic              grant_valid_q;
   logic              guard_q;
   logic [BC_W-1:0]   byte_cnt_q;
   logic [SC_W-1:0]   stall_cnt_q;
   logic              output_en_q;
   logic [7:0]        output_data_q;
   logic              err_stall_q;
   logic              err_len_q;

   logic [ID_W-1:0]   winner_c;
   logic              any_c;
   logic [7:0]        data_arr [N_REQ];
   logic              cur_valid_c;
   logic              cur_last_c;
   logic [7:0]        cur_data_c;
   logic              slot_open_c;
   logic              accept_c;

   // Round-robin choice among waiting requesters, starting at rr_ptr.
   rr_pointer_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .req_i    (req_valid),
      .ptr_i    (rr_ptr_q),
      .winner_o (winner_c),
      .any_o    (any_c)
   );

   // Split the flat data bus into one byte per requester.
   for (genvar i = 0; i < N_REQ; i++) begin : g_split
      assign data_arr[i] = req_data[8*i +: 8];
   end

   // Owner's handshake view and the one-byte-per-slot accept condition.
   assign cur_valid_c = req_valid[grant_id_q];
   assign cur_last_c  = req_last[grant_id_q];
   assign cur_data_c  = data_arr[grant_id_q];
   assign slot_open_c = (state_q == XFER) && !output_busy && !guard_q;
   assign accept_c    = slot_open_c && cur_valid_c;

   // After a release the current owner drops to lowest priority.
   assign rr_ptr_d = (32'(grant_id_q) == N_REQ - 1) ? '0 : grant_id_q + ID_W'(1);

   // Ready goes only to the owner, and only when a strobe slot is free.
   always_comb begin
      req_ready = '0;
      if (slot_open_c) begin
         req_ready[grant_id_q] = 1'b1;
      end
   end

   // Arbitration FSM with registered strobe, data, grant and error outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         guard_q       <= 1'b0;
         byte_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         output_en_q   <= 1'b0;
         output_data_q <= '0;
         err_stall_q   <= 1'b0;
         err_len_q     <= 1'b0;
      end else begin
         output_en_q <= 1'b0;
         guard_q     <= 1'b0;
         err_stall_q <= 1'b0;
         err_len_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_c) begin
                  state_q       <= XFER;
                  grant_id_q    <= winner_c;
                  grant_valid_q <= 1'b1;
                  byte_cnt_q    <= '0;
                  stall_cnt_q   <= '0;
               end
            end
            XFER: begin
               if (accept_c) begin
                  output_en_q   <= 1'b1;
                  output_data_q <= cur_data_c;
                  guard_q       <= 1'b1;
                  byte_cnt_q    <= byte_cnt_q + BC_W'(1);
                  stall_cnt_q   <= '0;
                  if (cur_last_c || (byte_cnt_q == BC_W'(MAX_MSG - 1))) begin
                     state_q       <= IDLE;
                     grant_valid_q <= 1'b0;
                     rr_ptr_q      <= rr_ptr_d;
                     err_len_q     <= !cur_last_c;
                  end
               end else if (!cur_valid_c) begin
                  stall_cnt_q <= stall_cnt_q + SC_W'(1);
                  if (stall_cnt_q == SC_W'(STALL_CYCLES - 1)) begin
                     state_q       <= IDLE;
                     grant_valid_q <= 1'b0;
                     rr_ptr_q      <= rr_ptr_d;
                     err_stall_q   <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign output_en   = output_en_q;
   assign output_data = output_data_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign err_stall   = err_stall_q;
   assign err_len     = err_len_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle tables plus hand sequences for busy, cap, stall.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic        output_busy;
   logic        output_en;
   logic [7:0]  output_data;
   logic        grant_valid;
   logic        grant_id;
   logic        err_stall;
   logic        err_len;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ        (2),
      .MAX_MSG      (4),
      .STALL_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .output_busy (output_busy),
      .output_en   (output_en),
      .output_data (output_data),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .err_stall   (err_stall),
      .err_len     (err_len)
   );

   // One cycle of inputs and the outputs expected while those inputs are applied.
   typedef struct packed {
      logic [1:0] v;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] l;
      logic       busy;
      logic [1:0] rdy;
      logic       en;
      logic [7:0] data;
      logic       gv;
      logic       gid;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [1:0] l, input logic busy, input logic [1:0] rdy,
                               input logic en, input logic [7:0] data, input logic gv,
                               input logic gid);
      vec_t r;
      r.v = v; r.d0 = d0; r.d1 = d1; r.l = l; r.busy = busy;
      r.rdy = rdy; r.en = en; r.data = data; r.gv = gv; r.gid = gid;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Requester models: queued {last, byte} entries, held until accepted.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [7:0] log_d[$];
   int         log_c[$];
   logic       log_g[$];
   int         cyc;
   int         es_cnt, es_cyc, el_cnt, el_cyc;
   logic [1:0] s_ready;
   logic       s_en, s_gv, s_es;

   task automatic step(input logic busy);
      @(posedge clk);
      #1;
      output_busy    = busy;
      req_valid[0]   = (q0.size() > 0);
      req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      req_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
      req_valid[1]   = (q1.size() > 0);
      req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      req_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
      #3;
      s_ready = req_ready;
      s_en    = output_en;
      s_gv    = grant_valid;
      s_es    = err_stall;
      if (output_en) begin
         log_d.push_back(output_data);
         log_c.push_back(cyc);
         log_g.push_back(grant_id);
      end
      if (err_stall) begin es_cnt++; es_cyc = cyc; end
      if (err_len)   begin el_cnt++; el_cyc = cyc; end
      if (req_ready[0] && req_valid[0]) void'(q0.pop_front());
      if (req_ready[1] && req_valid[1]) void'(q1.pop_front());
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0; req_data = '0; req_last = '0; output_busy = 1'b0;
      q0.delete(); q1.delete();
      log_d.delete(); log_c.delete(); log_g.delete();
      es_cnt = 0; el_cnt = 0; es_cyc = -1; el_cyc = -1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic check_log(input string tag, input string exp);
      check($sformatf("%s count", tag), 32'(log_d.size()), 32'(exp.len()));
      for (int i = 0; i < exp.len(); i++) begin
         if (i < log_d.size()) begin
            check($sformatf("%s byte%0d", tag, i), 32'(log_d[i]), 32'(exp[i]));
         end
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         @(posedge clk);
         #1;
         req_valid   = tbl[i].v;
         req_data    = {tbl[i].d1, tbl[i].d0};
         req_last    = tbl[i].l;
         output_busy = tbl[i].busy;
         #3;
         check($sformatf("row%0d ready", i), 32'(req_ready), 32'(tbl[i].rdy));
         check($sformatf("row%0d en", i), 32'(output_en), 32'(tbl[i].en));
         if (tbl[i].en) check($sformatf("row%0d data", i), 32'(output_data), 32'(tbl[i].data));
         check($sformatf("row%0d gv", i), 32'(grant_valid), 32'(tbl[i].gv));
         if (tbl[i].gv) check($sformatf("row%0d gid", i), 32'(grant_id), 32'(tbl[i].gid));
         check($sformatf("row%0d err", i), 32'({err_stall, err_len}), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Single requester 0 sends "12\n"; then both request and rr_ptr=1 favours requester 1.
      tbl[0]  = mk(2'b01, 8'h31, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0);
      tbl[1]  = mk(2'b01, 8'h31, 8'h00, 2'b00, 0, 2'b01, 0, 8'h00, 1, 0);
      tbl[2]  = mk(2'b01, 8'h32, 8'h00, 2'b00, 0, 2'b00, 1, 8'h31, 1, 0);
      tbl[3]  = mk(2'b01, 8'h32, 8'h00, 2'b00, 0, 2'b01, 0, 8'h00, 1, 0);
      tbl[4]  = mk(2'b01, 8'h0A, 8'h00, 2'b01, 0, 2'b00, 1, 8'h32, 1, 0);
      tbl[5]  = mk(2'b01, 8'h0A, 8'h00, 2'b01, 0, 2'b01, 0, 8'h00, 1, 0);
      tbl[6]  = mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 1, 8'h0A, 0, 0);
      tbl[7]  = mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0);
      tbl[8]  = mk(2'b11, 8'h41, 8'h42, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0);
      tbl[9]  = mk(2'b11, 8'h41, 8'h42, 2'b00, 0, 2'b10, 0, 8'h00, 1, 1);
      tbl[10] = mk(2'b11, 8'h41, 8'h43, 2'b00, 0, 2'b00, 1, 8'h42, 1, 1);
      // Both requesters valid right after reset: "a\n" from 0, then "b\n" from 1.
      tbl[11] = mk(2'b11, 8'h61, 8'h62, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0);
      tbl[12] = mk(2'b11, 8'h61, 8'h62, 2'b00, 0, 2'b01, 0, 8'h00, 1, 0);
      tbl[13] = mk(2'b11, 8'h0A, 8'h62, 2'b01, 0, 2'b00, 1, 8'h61, 1, 0);
      tbl[14] = mk(2'b11, 8'h0A, 8'h62, 2'b01, 0, 2'b01, 0, 8'h00, 1, 0);
      tbl[15] = mk(2'b10, 8'h00, 8'h62, 2'b00, 0, 2'b00, 1, 8'h0A, 0, 0);
      tbl[16] = mk(2'b10, 8'h00, 8'h62, 2'b00, 0, 2'b10, 0, 8'h00, 1, 1);
      tbl[17] = mk(2'b10, 8'h00, 8'h0A, 2'b10, 0, 2'b00, 1, 8'h62, 1, 1);
      tbl[18] = mk(2'b10, 8'h00, 8'h0A, 2'b10, 0, 2'b10, 0, 8'h00, 1, 1);
      tbl[19] = mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 1, 8'h0A, 0, 0);

      // Reset state.
      rst = 1'b1;
      req_valid = '0; req_data = '0; req_last = '0; output_busy = 1'b0;
      es_cnt = 0; el_cnt = 0; es_cyc = -1; el_cyc = -1; cyc = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset en", 32'(output_en), 32'd0);
      check("reset data", 32'(output_data), 32'd0);
      check("reset gv", 32'(grant_valid), 32'd0);
      check("reset gid", 32'(grant_id), 32'd0);
      check("reset err", 32'({err_stall, err_len}), 32'd0);
      check("reset ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_rows(0, 10);

      // Asynchronous reset between two bytes of requester 1's message.
      #1 rst = 1'b1;
      #1;
      check("async rst en", 32'(output_en), 32'd0);
      check("async rst gv", 32'(grant_valid), 32'd0);
      check("async rst data", 32'(output_data), 32'd0);
      req_valid = '0; req_data = '0; req_last = '0;
      @(negedge clk);
      rst = 1'b0;
      q0.delete(); q1.delete(); log_d.delete(); log_c.delete(); log_g.delete();
      for (int k = 0; k < 5; k++) begin
         step(1'b0);
         check($sformatf("post rst quiet%0d", k), 32'({s_en, s_gv}), 32'd0);
      end

      // Rotation from reset: rr_ptr back at 0, so requester 0 goes first.
      run_rows(11, 19);

      // Busy held for 10 cycles mid-message.
      do_reset();
      q0 = '{9'h048, 9'h049, 9'h10A};
      repeat (3) step(1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b1);
         check($sformatf("busy%0d ready", k), 32'(s_ready), 32'd0);
         check($sformatf("busy%0d en", k), 32'(s_en), 32'd0);
         check($sformatf("busy%0d stall", k), 32'(s_es), 32'd0);
      end
      repeat (12) step(1'b0);
      check_log("busy log", "HI\n");
      if (log_c.size() >= 2) begin
         check("busy first strobe cyc", 32'(log_c[0]), 32'd2);
         check("busy resume strobe cyc", 32'(log_c[1]), 32'd14);
      end
      check("busy err counts", 32'(es_cnt + el_cnt), 32'd0);

      // Length cap of 4: six-byte message is split, requester 1 slots in between.
      do_reset();
      q0 = '{9'h041, 9'h042, 9'h043, 9'h044, 9'h045, 9'h146};
      q1 = '{9'h07A, 9'h10A};
      repeat (40) step(1'b0);
      check_log("cap log", "ABCDz\nEF");
      check("cap err_len count", 32'(el_cnt), 32'd1);
      check("cap err_stall count", 32'(es_cnt), 32'd0);
      if (log_c.size() >= 5) begin
         check("cap err_len cyc", 32'(el_cyc), 32'(log_c[3]));
         check("cap next owner", 32'(log_g[4]), 32'd1);
      end

      // Stall watchdog of 8: requester 0 goes silent after one byte.
      do_reset();
      q0 = '{9'h053};
      q1 = '{9'h054, 9'h10A};
      repeat (30) step(1'b0);
      check_log("stall log", "ST\n");
      check("stall err_stall count", 32'(es_cnt), 32'd1);
      check("stall err_len count", 32'(el_cnt), 32'd0);
      if (log_c.size() >= 2) begin
         check("stall delay", 32'(es_cyc - log_c[0]), 32'd8);
         check("stall next owner", 32'(log_g[1]), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
